gnb_param_est: RTL and testbench
================================

# gnb_param_est

Streaming parameter estimator for the Gaussian naive Bayes datapath. It consumes labelled training samples for one class and produces the per-dimension `theta` (mean) and `sigma` (inverse-spread weight) vectors. These are exactly the values the distance stage reads. One instance serves one class; the host streams that class's sample set twice, first to estimate the mean and then to estimate the deviation.

## Interface
- `W`, 16: sample and parameter width; signed two's complement.
- `DIMS`, 6: feature dimensions per sample.
- `LOG_N`, 4: log2 of the sample count per pass (N = 2^LOG_N).
- `FRAC`, 8: fixed-point scale of `sigma`. Legal range is 1..W-2.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: begin estimation.
- `in_valid` in 1: `din` holds a sample.
- `in_ready` out 1: block accepts a sample this cycle.
- `din[DIMS]` in W each: sample vector, signed.
- `pass` out 1: 0 during the mean pass, 1 during the deviation pass.
- `busy` out 1: high in MEAN, DEV and DIV.
- `params_valid` out 1: `theta` and `sigma` are final.
- `theta[DIMS]` out W each: signed mean.
- `sigma[DIMS]` out W each: unsigned weight, floor(2^FRAC / max(mad,1)).

## Operation
- States are IDLE, MEAN, DEV, DIV and DONE. Reset enters IDLE.
- IDLE/DONE → MEAN on `start`.
  - The transition clears the accumulators, the sample counter, `theta`, `sigma` and `params_valid`.
  - `start` is ignored in MEAN, DEV and DIV.
- MEAN:
  - `in_ready`=1.
  - A sample is taken only on a handshake (`in_valid`&&`in_ready`).
  - `acc[i]` += sign-extended `din[i]`; accumulator width is W+LOG_N.
  - On the N-th handshake: `theta[i]` ← `acc[i]` >>> LOG_N (arithmetic shift, floor). The accumulators and counter clear, and the state goes to DEV.
- DEV:
  - `in_ready`=1.
  - `acc[i]` += |`din[i]` − `theta[i]`|, computed in W+1 bits, so there is no overflow.
  - On the N-th handshake: `mad[i]` ← `acc[i]` >> LOG_N (W+1 bits unsigned). The state goes to DIV.
- DIV:
  - `in_ready`=0.
  - A sequential restoring divider processes one dimension at a time, index 0 first.
  - Dividend is 2^FRAC; divisor is `mad[i]`, with 0 substituted by 1.
  - One quotient bit per cycle, FRAC+1 cycles per dimension.
  - The quotient is at most 2^FRAC, so it always fits W bits and no saturation is needed.
  - `sigma[i]` is written when its division completes.
  - After dimension DIMS-1 the state goes to DONE.
- DONE:
  - `params_valid`=1, `busy`=0.
  - `theta` and `sigma` are held until the next `start` or reset.
- `pass` is 1 only in DEV; it is 0 in every other state.
- Samples presented while `in_ready`=0 are not consumed and not counted.

## Timing
- Reset value of every output is 0: `in_ready`, `pass`, `busy`, `params_valid`, all `theta` and all `sigma`.
- `start` sampled at edge k → state is MEAN after edge k. `in_ready`=1 and `busy`=1 from that cycle.
- N-th MEAN handshake at edge m → `theta` is updated and `pass`=1 after edge m.
- N-th DEV handshake at edge d → DIV begins after edge d, with `in_ready`=0.
- DIV lasts exactly DIMS·(FRAC+1) cycles. `params_valid` rises d + DIMS·(FRAC+1) cycles later, in the same cycle `busy` falls.
- Minimum total from `start` to `params_valid` = 2N + DIMS·(FRAC+1) + 1 cycles.
- `start` in DONE → `params_valid`=0 and outputs cleared after that edge.
- `rst_n` low at any time, including mid-DIV:
  - outputs are forced to 0 immediately, without waiting for a clock edge;
  - the state goes to IDLE;
  - no partial results survive.

## Test plan
Settings for all scenarios: W=16, DIMS=2, LOG_N=2, FRAC=8.

- Constant samples (10,−5), 4 per pass, `in_valid` held high → `theta`=(10,−5), mad 0 → `sigma`=(256,256). `params_valid` rises 18 cycles after the last DEV handshake.
- dim0 = 0,2,4,6 and dim1 = −1,−2,−3,−4, repeated in both passes:
  - `theta`=(3,−3); dim1 is floor(−10/4).
  - mad=(2,1).
  - `sigma`=(128,256).
- Previous scenario with `in_valid` toggled pseudo-randomly → identical results; exactly 4 handshakes counted per pass; `pass` flips only after the 4th MEAN handshake.
- Extremes:
  - dim0 = 32767, −32768, 32767, −32768 → `theta`[0]=−1 and mad 32767, so `sigma`[0]=0.
  - dim1 = 0 → `theta`[1]=0 and `sigma`[1]=256.
- `start` pulsed during MEAN and DIV → ignored; results unchanged. `start` in DONE → `params_valid`=0 and `theta`/`sigma`=0 next cycle, then a fresh run completes correctly.
- `rst_n` asserted mid-DIV → all outputs 0 immediately and `in_ready` stays 0 until `start`. A subsequent full run matches the second scenario.

Source files
------------

// File: rtl/gnb_param_est.sv
// Per-class Gaussian naive Bayes parameter estimator. It makes a mean pass and a mean-absolute-
// deviation pass over the streamed samples, then runs a bit-serial reciprocal to produce the sigma weights.
module gnb_param_est #(
  parameter int W     = 16,
  parameter int DIMS  = 6,
  parameter int LOG_N = 4,
  parameter int FRAC  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] din [DIMS],
  output logic                pass,
  output logic                busy,
  output logic                params_valid,
  output logic signed [W-1:0] theta [DIMS],
  output logic        [W-1:0] sigma [DIMS],
  output logic        [2:0]   dbg_state
);
  localparam int ACC_W = W + LOG_N;
  localparam int MAD_W = W + 1;
  localparam int Q_W   = FRAC + 1;
  localparam int BIT_W = $clog2(FRAC + 1);
  localparam int DIM_W = (DIMS > 1) ? $clog2(DIMS) : 1;

  typedef enum logic [2:0] {IDLE, MEAN, DEV, DIV, DONE} state_t;

  // A sample moves only on the cycle where in_valid && in_ready are both high. Nothing is
  // consumed otherwise. in_ready depends only on the state, so it never depends on in_valid.
  state_t              state_q, state_d;
  logic [ACC_W-1:0]    acc_q [DIMS], acc_d [DIMS], acc_nx [DIMS];
  logic [MAD_W-1:0]    mad_q [DIMS], mad_d [DIMS];
  logic signed [W-1:0] theta_q [DIMS], theta_d [DIMS];
  logic [W-1:0]        sigma_q [DIMS], sigma_d [DIMS];
  logic signed [W:0]   diff [DIMS];
  logic [MAD_W-1:0]    absd [DIMS];
  logic [LOG_N-1:0]    cnt_q, cnt_d;
  logic [MAD_W-1:0]    rem_q, rem_d, divisor;
  logic [MAD_W:0]      rem_sh;
  logic [Q_W-1:0]      quo_q, quo_d, quo_nx;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [DIM_W-1:0]    dim_q, dim_d;
  logic                hs;

  assign in_ready     = (state_q == MEAN) || (state_q == DEV);
  assign pass         = (state_q == DEV);
  assign busy         = (state_q == MEAN) || (state_q == DEV) || (state_q == DIV);
  assign params_valid = (state_q == DONE);
  assign theta        = theta_q;
  assign sigma        = sigma_q;
  assign dbg_state    = state_q;
  assign hs           = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mad_d   = mad_q;
    theta_d = theta_q;
    sigma_d = sigma_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    bit_d   = bit_q;
    dim_d   = dim_q;
    for (int i = 0; i < DIMS; i++) begin
      diff[i]   = {din[i][W-1], din[i]} - {theta_q[i][W-1], theta_q[i]};
      absd[i]   = diff[i][W] ? MAD_W'(-diff[i]) : MAD_W'(diff[i]);
      acc_nx[i] = (state_q == DEV) ? acc_q[i] + ACC_W'(absd[i])
                                   : acc_q[i] + {{LOG_N{din[i][W-1]}}, din[i]};
    end
    // The dividend 2^FRAC has a single set bit, so that bit is fed in only on the first step.
    divisor = (mad_q[dim_q] == '0) ? MAD_W'(1) : mad_q[dim_q];
    rem_sh  = {rem_q, bit_q == BIT_W'(FRAC)};
    quo_nx  = quo_q;
    if (rem_sh >= {1'b0, divisor}) quo_nx[bit_q] = 1'b1;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          for (int i = 0; i < DIMS; i++) begin
            acc_d[i]   = '0;
            mad_d[i]   = '0;
            theta_d[i] = '0;
            sigma_d[i] = '0;
          end
          cnt_d   = '0;
          state_d = MEAN;
        end
      end
      MEAN: begin
        if (hs) begin
          acc_d = acc_nx;
          cnt_d = cnt_q + LOG_N'(1);
          if (&cnt_q) begin
            for (int i = 0; i < DIMS; i++) begin
              theta_d[i] = W'($signed(acc_nx[i]) >>> LOG_N);
              acc_d[i]   = '0;
            end
            state_d = DEV;
          end
        end
      end
      DEV: begin
        if (hs) begin
          acc_d = acc_nx;
          cnt_d = cnt_q + LOG_N'(1);
          if (&cnt_q) begin
            for (int i = 0; i < DIMS; i++) begin
              mad_d[i] = MAD_W'(acc_nx[i] >> LOG_N);
              acc_d[i] = '0;
            end
            rem_d   = '0;
            quo_d   = '0;
            bit_d   = BIT_W'(FRAC);
            dim_d   = '0;
            state_d = DIV;
          end
        end
      end
      DIV: begin
        rem_d = (rem_sh >= {1'b0, divisor}) ? MAD_W'(rem_sh - {1'b0, divisor})
                                            : rem_sh[MAD_W-1:0];
        quo_d = quo_nx;
        bit_d = bit_q - BIT_W'(1);
        if (bit_q == '0) begin
          sigma_d[dim_q] = W'(quo_nx);
          rem_d = '0;
          quo_d = '0;
          bit_d = BIT_W'(FRAC);
          if (dim_q == DIM_W'(DIMS - 1)) state_d = DONE;
          else                           dim_d   = dim_q + DIM_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      for (int i = 0; i < DIMS; i++) begin
        acc_q[i]   <= '0;
        mad_q[i]   <= '0;
        theta_q[i] <= '0;
        sigma_q[i] <= '0;
      end
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      bit_q <= '0;
      dim_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mad_q   <= mad_d;
      theta_q <= theta_d;
      sigma_q <= sigma_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      bit_q   <= bit_d;
      dim_q   <= dim_d;
    end
  end
endmodule

// File: tb/tb_gnb_param_est.sv
// Bench for gnb_param_est: directed and random sample sets, with results compared against an
// arithmetic model of mean, floor, mean absolute deviation and reciprocal weight.
module tb_gnb_param_est;
  localparam int W = 16, DIMS = 2, LOG_N = 2, FRAC = 8, N = 4;

  logic                clk = 1'b0;
  logic                rst_n, start, in_valid;
  logic                in_ready, pass, busy, params_valid;
  logic signed [W-1:0] din [DIMS];
  logic signed [W-1:0] theta [DIMS];
  logic        [W-1:0] sigma [DIMS];
  logic        [2:0]   dbg_state;

  int         checks = 0;
  int         passed = 0;
  int         smp [N][DIMS];
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  gnb_param_est #(.W(W), .DIMS(DIMS), .LOG_N(LOG_N), .FRAC(FRAC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .din(din), .pass(pass), .busy(busy), .params_valid(params_valid),
    .theta(theta), .sigma(sigma), .dbg_state(dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: floor mean, then mean |x - theta|, then 2^FRAC / max(mad,1).
  task automatic model();
    int sum, m, ad;
    int th [DIMS];
    int sg [DIMS];
    for (int d = 0; d < DIMS; d++) begin
      sum = 0;
      for (int k = 0; k < N; k++) sum += smp[k][d];
      th[d] = sum / N;
      if ((sum % N != 0) && (sum < 0)) th[d] = th[d] - 1;
      sum = 0;
      for (int k = 0; k < N; k++) begin
        ad = smp[k][d] - th[d];
        if (ad < 0) ad = -ad;
        sum += ad;
      end
      m = sum / N;
      if (m == 0) m = 1;
      sg[d] = (1 << FRAC) / m;
    end
    for (int d = 0; d < DIMS; d++) exp_q.push_back(W'(th[d]));
    for (int d = 0; d < DIMS; d++) exp_q.push_back(W'(sg[d]));
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_params_valid"}, params_valid, 0);
    for (int d = 0; d < DIMS; d++) begin
      check($sformatf("%s_theta%0d", tag, d), {16'h0, theta[d]}, 0);
      check($sformatf("%s_sigma%0d", tag, d), {16'h0, sigma[d]}, 0);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_in_ready", in_ready, 1);
    check("start_busy", busy, 1);
    check("start_params_valid", params_valid, 0);
    check("start_pass", pass, 0);
    for (int d = 0; d < DIMS; d++) begin
      check($sformatf("start_theta%0d", d), {16'h0, theta[d]}, 0);
      check($sformatf("start_sigma%0d", d), {16'h0, sigma[d]}, 0);
    end
  endtask

  task automatic drive_pass(input bit is_dev, input bit rand_valid, input bit pulse_start);
    int idx = 0;
    int cyc = 0;
    bit hs;
    while (idx < N && cyc < 60) begin
      in_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      for (int d = 0; d < DIMS; d++)
        din[d] = in_valid ? W'(smp[idx][d]) : W'($urandom_range(0, 65535));
      start = pulse_start && (idx == 1);
      hs = in_valid && in_ready;
      tick();
      cyc++;
      if (hs) idx++;
      if (!is_dev) check("mean_pass_flag", pass, idx == N);
      else         check("dev_pass_flag", pass, idx < N);
    end
    in_valid = 1'b0;
    start    = 1'b0;
    check(is_dev ? "dev_handshakes" : "mean_handshakes", idx, N);
  endtask

  task automatic wait_done(input bit pulse_start);
    int cyc = 0;
    check("div_in_ready", in_ready, 0);
    check("div_busy", busy, 1);
    while (!params_valid && cyc < 100) begin
      start    = pulse_start && (cyc == 5);
      in_valid = 1'b1;
      for (int d = 0; d < DIMS; d++) din[d] = W'($urandom_range(0, 65535));
      tick();
      cyc++;
    end
    start    = 1'b0;
    in_valid = 1'b0;
    check("div_latency", cyc, DIMS * (FRAC + 1));
    check("done_busy", busy, 0);
    check("done_in_ready", in_ready, 0);
  endtask

  task automatic check_results();
    for (int d = 0; d < DIMS; d++)
      check($sformatf("theta%0d", d), {16'h0, theta[d]}, {16'h0, exp_q.pop_front()});
    for (int d = 0; d < DIMS; d++)
      check($sformatf("sigma%0d", d), {16'h0, sigma[d]}, {16'h0, exp_q.pop_front()});
  endtask

  task automatic run(input bit rand_valid, input bit pulse);
    model();
    do_start();
    drive_pass(1'b0, rand_valid, pulse);
    drive_pass(1'b1, rand_valid, 1'b0);
    wait_done(pulse);
    check_results();
  endtask

  task automatic fill_ramp();
    for (int k = 0; k < N; k++) begin
      smp[k][0] = 2 * k;
      smp[k][1] = -(k + 1);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    for (int d = 0; d < DIMS; d++) din[d] = '0;
    #12;
    check_zero_outputs("reset");
    tick();
    rst_n = 1'b1;
    in_valid = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    check_zero_outputs("idle");

    // Constant samples give zero deviation.
    for (int k = 0; k < N; k++) begin
      smp[k][0] = 10;
      smp[k][1] = -5;
    end
    run(1'b0, 1'b0);

    // Ramp: this run also starts from DONE.
    fill_ramp();
    run(1'b0, 1'b0);
    run(1'b1, 1'b0);

    // Extremes.
    for (int k = 0; k < N; k++) begin
      smp[k][0] = (k % 2 == 0) ? 32767 : -32768;
      smp[k][1] = 0;
    end
    run(1'b0, 1'b0);

    // start pulses during MEAN and DIV are ignored.
    fill_ramp();
    run(1'b1, 1'b1);

    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < N; k++)
        for (int d = 0; d < DIMS; d++)
          smp[k][d] = int'($urandom_range(0, 65535)) - 32768;
      run(1'b1, 1'b0);
    end

    // Reset in the middle of the divider.
    fill_ramp();
    do_start();
    drive_pass(1'b0, 1'b0, 1'b0);
    drive_pass(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("async_reset");
    #3;
    rst_n    = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_reset_in_ready", in_ready, 0);
      check("post_reset_busy", busy, 0);
    end
    in_valid = 1'b0;
    run(1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
